// File: rtl/ddr4_req_arbiter.sv
// ddr4_req_arbiter: two-port round-robin request arbiter in front of a DDR4 app interface, with read-tag routing.
// Define DDR4_ARB_STATS_EN to build the read/write issue counters; otherwise rd_cnt_o/wr_cnt_o are tied to 0.
module ddr4_req_arbiter #(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 512,
  parameter int MAX_OUTST = 8
) (
  input  logic                  ddr4_clk_i,
  input  logic                  ddr4_rst_i,
  input  logic                  calib_done_i,
  input  logic [1:0]            req_valid_i,
  output logic [1:0]            req_ready_o,
  input  logic [1:0]            req_wr_i,
  input  logic [2*ADDR_W-1:0]   req_addr_i,
  input  logic [2*DATA_W-1:0]   req_wdata_i,
  input  logic [2*DATA_W/8-1:0] req_wmask_i,
  output logic [1:0]            rsp_valid_o,
  output logic [DATA_W-1:0]     rsp_data_o,
  output logic                  app_en_o,
  output logic [2:0]            app_cmd_o,
  output logic [ADDR_W-1:0]     app_addr_o,
  input  logic                  app_rdy_i,
  output logic                  app_wdf_wren_o,
  output logic                  app_wdf_end_o,
  output logic [DATA_W-1:0]     app_wdf_data_o,
  output logic [DATA_W/8-1:0]   app_wdf_mask_o,
  input  logic                  app_wdf_rdy_i,
  input  logic                  app_rd_data_valid_i,
  input  logic [DATA_W-1:0]     app_rd_data_i,
  output logic                  err_o,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o
);
  localparam int AW = $clog2(MAX_OUTST);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {WAIT_CAL, IDLE, ISSUE} state_t;
  state_t r_state, w_nxt;
  logic r_lp, r_wr, r_id;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_wp, r_rp;
  logic r_tags [MAX_OUTST];
  logic w_gnt, w_acc, w_done, w_push, w_pop, w_full, w_empty, w_rdy_ok;
  always_comb begin
    w_full         = r_cnt == CW'(MAX_OUTST);
    w_empty        = r_cnt == '0;
    w_gnt          = &req_valid_i ? ~r_lp : req_valid_i[1];
    w_rdy_ok       = r_state == IDLE && calib_done_i && (req_wr_i[w_gnt] || !w_full);
    req_ready_o    = w_rdy_ok ? req_valid_i & (2'b01 << w_gnt) : 2'b00;
    w_acc          = |req_ready_o;
    app_en_o       = r_state == ISSUE;
    app_wdf_wren_o = app_en_o && r_wr;
    app_wdf_end_o  = app_en_o && r_wr;
    app_cmd_o      = {2'b00, app_en_o && !r_wr};
    w_done         = app_en_o && app_rdy_i && (!r_wr || app_wdf_rdy_i);
    w_push         = w_done && !r_wr;
    w_pop          = app_rd_data_valid_i && !w_empty;
    w_nxt          = r_state == WAIT_CAL ? (calib_done_i ? IDLE : WAIT_CAL)
                   : r_state == IDLE ? (!calib_done_i ? WAIT_CAL : w_acc ? ISSUE : IDLE)
                   : !w_done ? ISSUE : calib_done_i ? IDLE : WAIT_CAL;
  end
  always_ff @(posedge ddr4_clk_i) begin
    if (ddr4_rst_i) begin
      r_state        <= WAIT_CAL;
      r_lp           <= 1'b1;
      r_wr           <= 1'b0;
      r_id           <= 1'b0;
      app_addr_o     <= '0;
      app_wdf_data_o <= '0;
      app_wdf_mask_o <= '0;
      r_cnt          <= '0;
      r_wp           <= '0;
      r_rp           <= '0;
      rsp_valid_o    <= 2'b00;
      rsp_data_o     <= '0;
      err_o          <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_acc) begin
        r_lp           <= w_gnt;
        r_wr           <= req_wr_i[w_gnt];
        r_id           <= w_gnt;
        app_addr_o     <= w_gnt ? req_addr_i[2*ADDR_W-1:ADDR_W] : req_addr_i[ADDR_W-1:0];
        app_wdf_data_o <= w_gnt ? req_wdata_i[2*DATA_W-1:DATA_W] : req_wdata_i[DATA_W-1:0];
        app_wdf_mask_o <= w_gnt ? req_wmask_i[2*DATA_W/8-1:DATA_W/8] : req_wmask_i[DATA_W/8-1:0];
      end
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      r_cnt       <= r_cnt + CW'(w_push) - CW'(w_pop);
      rsp_valid_o <= w_pop ? 2'b01 << r_tags[r_rp] : 2'b00;
      if (w_pop) rsp_data_o <= app_rd_data_i;
      // read data with no outstanding tag is dropped and flagged until reset
      err_o <= err_o | (app_rd_data_valid_i && w_empty);
    end
  end
  always_ff @(posedge ddr4_clk_i)
    if (w_push) r_tags[r_wp] <= r_id;
`ifdef DDR4_ARB_STATS_EN
  logic [31:0] r_rd_cnt, r_wr_cnt;
  always_ff @(posedge ddr4_clk_i) begin
    if (ddr4_rst_i) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_push) r_rd_cnt <= r_rd_cnt + 32'd1;
      if (w_done && r_wr) r_wr_cnt <= r_wr_cnt + 32'd1;
    end
  end
  assign rd_cnt_o = r_rd_cnt;
  assign wr_cnt_o = r_wr_cnt;
`else
  assign rd_cnt_o = '0;
  assign wr_cnt_o = '0;
`endif
endmodule

// File: tb/tb_ddr4_req_arbiter.sv
// tb_ddr4_req_arbiter: directed bench for ddr4_req_arbiter covering calibration, round-robin, write stall, tag FIFO limits, orphans and reset.
module tb_ddr4_req_arbiter;
  localparam int AW = 28;
  localparam int DW = 512;
  localparam int MW = DW / 8;
  logic clk = 1'b0, rst = 1'b1, calib = 1'b0;
  logic [1:0] req_valid, req_ready, req_wr, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*MW-1:0] req_wmask;
  logic [DW-1:0] rsp_data, wdf_data, rd_data;
  logic [MW-1:0] wdf_mask;
  logic [AW-1:0] app_addr;
  logic [2:0] app_cmd;
  logic app_en, app_rdy, wren, wend, wdf_rdy, rd_valid, err;
  logic [31:0] rd_cnt, wr_cnt;
  logic [63:0] d;
  int n_cmp = 0, n_err = 0;
  ddr4_req_arbiter dut (
    .ddr4_clk_i(clk), .ddr4_rst_i(rst), .calib_done_i(calib),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wr_i(req_wr),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .app_en_o(app_en), .app_cmd_o(app_cmd), .app_addr_o(app_addr), .app_rdy_i(app_rdy),
    .app_wdf_wren_o(wren), .app_wdf_end_o(wend), .app_wdf_data_o(wdf_data),
    .app_wdf_mask_o(wdf_mask), .app_wdf_rdy_i(wdf_rdy),
    .app_rd_data_valid_i(rd_valid), .app_rd_data_i(rd_data),
    .err_o(err), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rdy;
    for (int t = 0; t < 8 && req_ready == 2'b00; t++) cyc();
  endtask
  initial begin
    req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; req_wmask = 0;
    app_rdy = 1; wdf_rdy = 1; rd_valid = 0; rd_data = 0;
    cyc(); cyc();
    chk("rst_app_en", app_en, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", app_addr, 0);
    chk("rst_cmd", app_cmd, 0);
    rst = 0;
    req_valid = 2'b01;
    req_addr = {28'h0, 28'h0000123};
    repeat (3) begin
      cyc();
      chk("nocal_ready", req_ready, 0);
      chk("nocal_en", app_en, 0);
    end
    calib = 1; #1;
    chk("cal_rise_ready", req_ready, 0);
    cyc();
    chk("cal_idle_ready", req_ready, 2'b01);
    chk("cal_idle_en", app_en, 0);
    cyc();
    req_valid = 0; #1;
    chk("cal_issue_en", app_en, 1);
    chk("cal_issue_cmd", app_cmd, 1);
    chk("cal_issue_addr", app_addr, 64'h123);
    cyc();
    chk("cal_done_en", app_en, 0);
    rd_valid = 1; rd_data = {8{64'hA5A5_0000_0000_0001}};
    cyc();
    rd_valid = 0;
    chk("rsp0_valid", rsp_valid, 2'b01);
    chk("rsp0_data", rsp_data[63:0], 64'hA5A5_0000_0000_0001);
    cyc();
    chk("rsp0_clear", rsp_valid, 0);
    rst = 1; cyc(); rst = 0;
    req_valid = 2'b11; req_wr = 2'b00;
    req_addr = {28'h0BBBBBB, 28'h0AAAAAA};
    for (int i = 0; i < 4; i++) begin
      #1;
      wait_rdy();
      chk($sformatf("rr_grant%0d", i), req_ready, i % 2 ? 2'b10 : 2'b01);
      cyc();
      chk($sformatf("rr_addr%0d", i), app_addr, i % 2 ? 64'h0BBBBBB : 64'h0AAAAAA);
      cyc();
    end
    req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      d = 64'h1000 + 64'(i);
      rd_valid = 1; rd_data = {8{d}};
      cyc();
      chk($sformatf("rr_rsp%0d", i), rsp_valid, i % 2 ? 2'b10 : 2'b01);
      chk($sformatf("rr_data%0d", i), rsp_data[63:0], d);
    end
    rd_valid = 0;
    cyc();
    chk("rr_rsp_idle", rsp_valid, 0);
    chk("rr_err", err, 0);
    req_valid = 2'b10; req_wr = 2'b10;
    req_addr = {28'h0CCCCCC, 28'h0};
    req_wdata = {{8{64'hDEAD_BEEF_0000_0032}}, 512'h0};
    req_wmask = {64'h0000_0000_0000_00F0, 64'h0};
    wdf_rdy = 0; #1;
    wait_rdy();
    chk("wr_grant", req_ready, 2'b10);
    cyc();
    req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("wr_hold_en%0d", i), app_en, 1);
      chk($sformatf("wr_hold_wren%0d", i), {wren, wend}, 2'b11);
      chk($sformatf("wr_hold_addr%0d", i), app_addr, 64'h0CCCCCC);
      cyc();
    end
    chk("wr_data", wdf_data[63:0], 64'hDEAD_BEEF_0000_0032);
    chk("wr_mask", wdf_mask[63:0], 64'hF0);
    chk("wr_cmd", app_cmd, 0);
    wdf_rdy = 1; app_rdy = 0; #1;
    chk("wr_hold_ardy", app_en, 1);
    cyc();
    app_rdy = 1; #1;
    chk("wr_last_wren", wren, 1);
    cyc();
    chk("wr_done_en", app_en, 0);
    chk("wr_done_wren", wren, 0);
`ifdef DDR4_ARB_STATS_EN
    chk("wr_cnt", wr_cnt, 1);
`else
    chk("wr_cnt", wr_cnt, 0);
`endif
    req_valid = 2'b01; req_wr = 2'b00;
    req_addr = {28'h0, 28'h0000900}; #1;
    for (int i = 0; i < 8; i++) begin
      wait_rdy();
      chk($sformatf("fill_grant%0d", i), req_ready, 2'b01);
      cyc(); cyc();
    end
    chk("full_block", req_ready, 0);
    cyc();
    chk("full_block2", req_ready, 0);
    rd_valid = 1; rd_data = {8{64'h900}};
    cyc();
    rd_valid = 0; #1;
    chk("full_pop_rsp", rsp_valid, 2'b01);
    chk("after_pop_ready", req_ready, 2'b01);
    cyc();
    rd_valid = 1;
    cyc();
    rd_valid = 0; #1;
    chk("coin_rsp", rsp_valid, 2'b01);
    chk("coin_ready", req_ready, 2'b01);
    cyc(); cyc();
    chk("refull_block", req_ready, 0);
    req_valid = 0;
    for (int i = 0; i < 8; i++) begin
      rd_valid = 1; rd_data = {8{64'h2000 + 64'(i)}};
      cyc();
      chk($sformatf("drain_rsp%0d", i), rsp_valid, 2'b01);
    end
    cyc();
    rd_valid = 0;
    chk("orphan_rsp", rsp_valid, 0);
    chk("orphan_err", err, 1);
    cyc(); cyc();
    chk("orphan_err_sticky", err, 1);
    chk("orphan_rsp_idle", rsp_valid, 0);
`ifdef DDR4_ARB_STATS_EN
    chk("rd_cnt", rd_cnt, 14);
`else
    chk("rd_cnt", rd_cnt, 0);
`endif
    req_valid = 2'b01; #1;
    for (int i = 0; i < 3; i++) begin
      wait_rdy();
      cyc(); cyc();
    end
    wait_rdy();
    app_rdy = 0;
    cyc();
    req_valid = 0; #1;
    chk("rst_pre_en", app_en, 1);
    rst = 1;
    cyc();
    chk("rst_mid_en", app_en, 0);
    chk("rst_mid_cmd", app_cmd, 0);
    chk("rst_mid_addr", app_addr, 0);
    chk("rst_mid_wren", {wren, wend}, 0);
    chk("rst_mid_ready", req_ready, 0);
    chk("rst_mid_rsp", rsp_valid, 0);
    chk("rst_mid_err", err, 0);
    chk("rst_mid_cnt", {rd_cnt, wr_cnt}, 0);
    rst = 0; app_rdy = 1;
    rd_valid = 1; rd_data = {8{64'h3000}};
    cyc();
    rd_valid = 0;
    chk("post_rst_rsp", rsp_valid, 0);
    chk("post_rst_err", err, 1);
    cyc();
    chk("post_rst_rsp2", rsp_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ddr4_req_arbiter.md
DDR4_REQ_ARBITER -- requirements
Module: ddr4_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, DDR4 application address width.
REQ-002 Parameter DATA_W, default 512, DDR4 application data width; DATA_W/8 mask bits.
REQ-003 Parameter MAX_OUTST, default 8, power of two, maximum outstanding reads.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of ddr4_clk_i.
REQ-005 ddr4_clk_i  in  1  DDR4 user clock.
REQ-006 ddr4_rst_i  in  1  synchronous active-high reset.
REQ-007 calib_done_i  in  1  DDR4 init calibration complete.
REQ-008 req_valid_i / req_ready_o  in/out  2  per-requester handshake; bit 0 = NoC port, bit 1 = auxiliary port.
REQ-009 req_wr_i  in  2  1 = write, 0 = read.
REQ-010 req_addr_i  in  2*ADDR_W  addresses; req_wdata_i  in  2*DATA_W; req_wmask_i  in  2*DATA_W/8 (1 = byte masked).
REQ-011 rsp_valid_o  out  2  one-hot read-response strobe; rsp_data_o  out  DATA_W  shared read data.
REQ-012 app_en_o, app_cmd_o (3; 0 = write, 1 = read), app_addr_o (ADDR_W), app_rdy_i.
REQ-013 app_wdf_wren_o, app_wdf_end_o, app_wdf_data_o (DATA_W), app_wdf_mask_o (DATA_W/8), app_wdf_rdy_i.
REQ-014 app_rd_data_valid_i, app_rd_data_i (DATA_W); err_o  out  1  sticky orphan-response flag.
REQ-015 rd_cnt_o, wr_cnt_o  out  32  statistics counters.

Function
REQ-016 FSM states: WAIT_CAL, IDLE, ISSUE.
- WAIT_CAL -> IDLE when calib_done_i = 1.
- IDLE -> ISSUE on request acceptance.
- ISSUE -> IDLE on app acceptance, or -> WAIT_CAL on app acceptance with calib_done_i = 0.
REQ-017 req_ready_o SHALL be asserted only in IDLE: for the granted requester only; for a read, only when the tag FIFO is not full.
REQ-018 Round-robin: last-grant pointer lp resets to 1; if both requesters are valid, grant ~lp; if one is valid, grant it; lp updates on every acceptance.
REQ-019 Accepted command, address, data, mask and requester id SHALL be registered; app outputs are driven from these registers in ISSUE, one cycle after acceptance.
REQ-020 Write in ISSUE: assert app_en_o, app_wdf_wren_o and app_wdf_end_o together; complete only in a cycle with app_rdy_i = 1 and app_wdf_rdy_i = 1; hold all outputs stable until then.
REQ-021 Read in ISSUE: assert app_en_o; complete on app_rdy_i = 1; push the requester id into the tag FIFO (depth MAX_OUTST) in the same cycle.
REQ-022 On app_rd_data_valid_i with the FIFO non-empty: pop; next cycle, rsp_valid_o[id] = 1 and rsp_data_o = registered app_rd_data_i. No backpressure.
REQ-023 Simultaneous push and pop SHALL leave the occupancy unchanged; occupancy SHALL never exceed MAX_OUTST (read readiness blocked at full).
REQ-024 app_rd_data_valid_i with an empty FIFO: discard the data, no rsp_valid_o, set err_o until reset.
REQ-025 Calibration loss in IDLE: go to WAIT_CAL next cycle; pending tags retained; responses still routed.

Reset
REQ-026 On ddr4_rst_i: state = WAIT_CAL, lp = 1, FIFO emptied.
REQ-027 On ddr4_rst_i, all outputs = 0; any ISSUE in progress is aborted.
REQ-028 Reset mid-operation SHALL drop in-flight commands and tags without generating responses.

Configuration
REQ-029 Macro DDR4_ARB_STATS_EN.
- Defined: rd_cnt_o / wr_cnt_o increment on each completed read / write issue, wrap at 2^32, clear on reset.
- Undefined: both outputs constant 0 and no counter logic exists.

Verification
REQ-030 calib_done_i = 0, req_valid_i = 2'b01 -> req_ready_o = 0, app_en_o = 0; raise calib -> accept 2 cycles later, app_en_o 1 cycle after accept.
REQ-031 Both requesters continuously issue reads after reset -> grants alternate 0,1,0,1; each rsp_valid_o bit matches its tag order.
REQ-032 Write with app_wdf_rdy_i held 0 for 5 cycles -> app outputs held stable; completes in the first cycle both ready signals are 1.
REQ-033 9 reads with no read data returned -> 8 accepted, 9th req_ready_o = 0; one app_rd_data_valid_i -> 9th accepted, with occupancy staying at 8 when push and pop coincide.
REQ-034 app_rd_data_valid_i pulse with an empty FIFO -> err_o = 1 and stays 1; rsp_valid_o = 0.
REQ-035 ddr4_rst_i asserted during ISSUE with 3 tags outstanding -> all outputs 0 next cycle; later read data produces no rsp_valid_o; with DDR4_ARB_STATS_EN, counters = 0.
